// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath reduction stage.
// Holds the reducer state encoding and the signed saturation helper.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SUM     = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Clamp a sign-extended accumulator value to the signed range of dw bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int unsigned              dw
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        min_v = ~max_v;
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/channel_capture.sv
// One channel's result capture: cReady rising-edge detect, capture register
// and full flag. A second edge while the flag is set is reported as overrun.
module channel_capture
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_ready,
    input  logic [DATA_WIDTH-1:0] c_sum,
    input  logic                  take,
    output logic                  flag,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  overrun_pulse
);

    logic ready_q;
    logic ready_qq;
    logic rise;

    assign rise = ready_q & ~ready_qq;

    // An edge coinciding with take belongs to the next tile, not an overrun.
    assign overrun_pulse = rise & flag & ~take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            ready_qq <= 1'b0;
            flag     <= 1'b0;
            data     <= '0;
        end else begin
            ready_q  <= c_ready;
            ready_qq <= ready_q;
            if (take) begin
                flag <= rise;
            end else if (rise) begin
                flag <= 1'b1;
            end
            if (rise && (take || !flag)) begin
                data <= c_sum;
            end
        end
    end

endmodule

// File: rtl/channel_sum_reducer.sv
// Sums all channel results plus bias with one sequential adder, then
// saturates, optionally applies ReLU and offers the pixel on valid/ready.
//
// state   | meaning
// COLLECT | waiting for every channel flag; captures keep arriving
// SUM     | one work-buffer entry added to acc per cycle
// OUT     | out_data/out_valid held until the consumer accepts
module channel_sum_reducer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = 1,
    parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(CHANNELS + 1) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] cSum,
    input  logic [CHANNELS-1:0]            cReady,
    input  logic [DATA_WIDTH-1:0]          bias,
    input  logic                           relu_en,
    input  logic                           clear,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WORK_N = 2 ** IDX_W;

    state_t state;
    state_t state_nxt;

    logic [CHANNELS-1:0]     flag;
    logic [CHANNELS-1:0]     ovr_pulse;
    logic [DATA_WIDTH-1:0]   cap_data [CHANNELS];
    logic [DATA_WIDTH-1:0]   work     [WORK_N];
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] work_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic [IDX_W-1:0]        idx;
    logic                    relu_q;
    logic [DATA_WIDTH-1:0]   sat_val;
    logic [DATA_WIDTH-1:0]   result;
    logic                    take;
    logic                    do_add;
    logic                    last_add;
    logic                    accept;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cap
        channel_capture #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cap (
            .clk          (clk),
            .rst_n        (rst_n),
            .c_ready      (cReady[g]),
            .c_sum        (cSum[g*DATA_WIDTH +: DATA_WIDTH]),
            .take         (take),
            .flag         (flag[g]),
            .data         (cap_data[g]),
            .overrun_pulse(ovr_pulse[g])
        );
    end

    assign work_ext = {{(ACC_WIDTH-DATA_WIDTH){work[idx][DATA_WIDTH-1]}}, work[idx]};
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    assign acc_sum  = acc + work_ext;
    assign last_add = (idx == IDX_W'(CHANNELS - 1));
    assign sat_val  = DATA_WIDTH'(sat_signed(SAT_W'(acc_sum), DATA_WIDTH));
    assign result   = (relu_q && sat_val[DATA_WIDTH-1]) ? '0 : sat_val;
    assign busy     = (state != COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        do_add    = 1'b0;
        accept    = 1'b0;
        case (state)
            COLLECT: begin
                if (&flag) begin
                    take      = 1'b1;
                    state_nxt = SUM;
                end
            end
            SUM: begin
                do_add = 1'b1;
                if (last_add) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    accept    = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORK_N; i++) begin
                work[i] <= '0;
            end
            acc       <= '0;
            idx       <= '0;
            relu_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (take) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    work[i] <= cap_data[i];
                end
                acc    <= bias_ext;
                relu_q <= relu_en;
                idx    <= '0;
            end
            if (do_add) begin
                acc <= acc_sum;
                idx <= idx + 1'b1;
                if (last_add) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                end
            end
            if (accept) begin
                out_valid <= 1'b0;
            end
            // A new overrun event outranks a clear in the same cycle.
            if (|ovr_pulse) begin
                overrun <= 1'b1;
            end else if (clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_channel_sum_reducer.sv
// Scoreboard bench: a 4-channel and a 1-channel reducer driven with directed
// and random tiles, checked against an arithmetic reference model.
module tb_channel_sum_reducer;

    localparam int DW = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [4*DW-1:0] c_sum4;
    logic [3:0]      c_ready4;
    logic [DW-1:0]   bias4;
    logic            relu4, clear4, out_ready4, out_valid4, busy4, overrun4;
    logic [DW-1:0]   out_data4;

    logic [DW-1:0]   c_sum1;
    logic [0:0]      c_ready1;
    logic [DW-1:0]   bias1;
    logic            relu1, clear1, out_ready1, out_valid1, busy1, overrun1;
    logic [DW-1:0]   out_data1;

    channel_sum_reducer #(.DATA_WIDTH(DW), .CHANNELS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cSum(c_sum4), .cReady(c_ready4), .bias(bias4),
        .relu_en(relu4), .clear(clear4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready4), .busy(busy4), .overrun(overrun4)
    );

    channel_sum_reducer #(.DATA_WIDTH(DW), .CHANNELS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cSum(c_sum1), .cReady(c_ready1), .bias(bias1),
        .relu_en(relu1), .clear(clear1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1), .overrun(overrun1)
    );

    logic [DW-1:0] exp_q4[$];
    logic [DW-1:0] exp_q1[$];
    int last_raise4 = 0;
    int last_raise1 = 0;
    bit rand_ready = 1'b0;
    bit ready_cmd4 = 1'b1;
    int tv[4];
    int od[4];

    function automatic logic [DW-1:0] ref_out(input longint s, input bit relu);
        longint r;
        if (s > MAXV) r = MAXV;
        else if (s < MINV) r = MINV;
        else r = s;
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    function automatic int rnd_val();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom);
            1: v = 32'h7FFF_FFFF - int'($urandom_range(0, 50));
            2: v = 32'h8000_0000 + int'($urandom_range(0, 50));
            default: v = int'($urandom_range(0, 2000)) - 1000;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push4(input int v[4], input int b, input bit r);
        longint s;
        s = longint'(b);
        for (int i = 0; i < 4; i++) s += longint'(v[i]);
        exp_q4.push_back(ref_out(s, r));
    endtask

    task automatic pulse4(input int ch, input int val);
        @(posedge clk); #1;
        c_sum4[ch*DW +: DW] = val;
        c_ready4[ch] = 1'b1;
        last_raise4 = cyc;
        @(posedge clk); #1;
        c_ready4[ch] = 1'b0;
    endtask

    task automatic send4(input int v[4], input int b, input bit r, input bit push,
                         input int o[4], input int max_gap);
        bias4 = b;
        relu4 = r;
        if (push) push4(v, b, r);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            pulse4(o[i], v[o[i]]);
        end
    endtask

    task automatic send1(input int v, input int b, input bit r);
        bias1 = b;
        relu1 = r;
        exp_q1.push_back(ref_out(longint'(b) + longint'(v), r));
        @(posedge clk); #1;
        c_sum1 = v;
        c_ready1 = 1'b1;
        last_raise1 = cyc;
        @(posedge clk); #1;
        c_ready1 = 1'b0;
    endtask

    task automatic wait_idle4();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy4 && !out_valid4 && exp_q4.size() == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL idle4: timeout, %0d results still required", exp_q4.size());
    endtask

    task automatic wait_idle1();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy1 && !out_valid1 && exp_q1.size() == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL idle1: timeout, %0d results still required", exp_q1.size());
    endtask

    task automatic wait_valid4();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid4) return;
        end
    endtask

    task automatic shuffle();
        int j;
        int t;
        od = '{0, 1, 2, 3};
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = od[i];
            od[i] = od[j];
            od[j] = t;
        end
    endtask

    initial begin
        out_ready4 = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready4 = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd4;
        end
    end

    logic          prev_hold4 = 1'b0;
    logic [DW-1:0] prev_data4 = '0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst_n) begin
            prev_hold4 = 1'b0;
        end else begin
            if (prev_hold4) begin
                tests++;
                if (!out_valid4 || out_data4 !== prev_data4) begin
                    fails++;
                    $display("FAIL hold4: valid=%0b data=%h required valid=1 data=%h",
                             out_valid4, out_data4, prev_data4);
                end
            end
            if (out_valid4 && out_ready4) begin
                tests++;
                if (exp_q4.size() == 0) begin
                    fails++;
                    $display("FAIL out4: unexpected result %h, none required", out_data4);
                end else begin
                    e = exp_q4.pop_front();
                    if (out_data4 !== e) begin
                        fails++;
                        $display("FAIL out4: got %h required %h", out_data4, e);
                    end
                end
            end
            prev_hold4 = out_valid4 && !out_ready4;
            prev_data4 = out_data4;
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n && out_valid1 && out_ready1) begin
            tests++;
            if (exp_q1.size() == 0) begin
                fails++;
                $display("FAIL out1: unexpected result %h, none required", out_data1);
            end else begin
                e = exp_q1.pop_front();
                if (out_data1 !== e) begin
                    fails++;
                    $display("FAIL out1: got %h required %h", out_data1, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL global: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

    initial begin
        c_sum4 = '0; c_ready4 = '0; bias4 = '0; relu4 = 1'b0; clear4 = 1'b0;
        c_sum1 = '0; c_ready1 = '0; bias1 = '0; relu1 = 1'b0; clear1 = 1'b0;
        out_ready1 = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        check("rst_out_data", out_data4, '0);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_overrun", 32'(overrun4), 32'd0);
        #18 rst_n = 1'b1;

        // basic tile with staggered edges and latency
        tv = '{10, -3, 7, 1};
        od = '{2, 0, 3, 1};
        send4(tv, 5, 1'b0, 1'b1, od, 2);
        wait_valid4();
        check("latency4", 32'(cyc - last_raise4), 32'd7);
        wait_idle4();

        // same tile, reset pulsed after the first add
        od = '{0, 1, 2, 3};
        send4(tv, 5, 1'b0, 1'b0, od, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_data", out_data4, '0);
        check("midrst_out_valid", 32'(out_valid4), 32'd0);
        check("midrst_busy", 32'(busy4), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_out_valid", 32'(out_valid4), 32'd0);
        check("postrst_busy", 32'(busy4), 32'd0);
        check("postrst_overrun", 32'(overrun4), 32'd0);
        send4(tv, 5, 1'b0, 1'b1, od, 1);
        wait_idle4();

        // ReLU and saturation corners
        tv = '{-100, 0, 0, 0};
        send4(tv, 0, 1'b1, 1'b1, od, 0);
        wait_idle4();
        send4(tv, 0, 1'b0, 1'b1, od, 0);
        wait_idle4();
        tv = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        send4(tv, 1, 1'b0, 1'b1, od, 0);
        wait_idle4();
        tv = '{32'h8000_0000, 32'h8000_0000, -5, 3};
        send4(tv, -1, 1'b0, 1'b1, od, 0);
        wait_idle4();

        // overrun: channel 2 reports twice before the tile completes
        tv = '{11, 22, 33, 44};
        bias4 = 100;
        relu4 = 1'b0;
        push4(tv, 100, 1'b0);
        pulse4(0, 11);
        pulse4(1, 22);
        pulse4(2, 33);
        pulse4(2, 999);
        repeat (2) @(negedge clk);
        check("overrun_set", 32'(overrun4), 32'd1);
        pulse4(3, 44);
        wait_idle4();
        check("overrun_sticky", 32'(overrun4), 32'd1);
        @(posedge clk); #1 clear4 = 1'b1;
        @(posedge clk); #1 clear4 = 1'b0;
        @(negedge clk);
        check("overrun_clear", 32'(overrun4), 32'd0);

        // next-tile edge on channel 0 coinciding with the start of reduction
        tv = '{1, 2, 3, 4};
        bias4 = 0;
        push4(tv, 0, 1'b0);
        pulse4(0, 1);
        pulse4(1, 2);
        pulse4(2, 3);
        @(posedge clk); #1;
        c_sum4[3*DW +: DW] = 4;
        c_ready4[3] = 1'b1;
        @(posedge clk); #1;
        c_ready4[3] = 1'b0;
        c_sum4[0 +: DW] = 1000;
        c_ready4[0] = 1'b1;
        @(posedge clk); #1;
        c_ready4[0] = 1'b0;
        @(posedge clk); #1;
        bias4 = -7;
        tv = '{1000, 20, 30, 40};
        push4(tv, -7, 1'b0);
        pulse4(1, 20);
        pulse4(2, 30);
        pulse4(3, 40);
        wait_idle4();
        check("simul_no_overrun", 32'(overrun4), 32'd0);

        // back-pressure with the next tile captured during OUT
        ready_cmd4 = 1'b0;
        @(posedge clk);
        tv = '{-50, 60, -70, 80};
        send4(tv, 3, 1'b1, 1'b1, od, 0);
        wait_valid4();
        tv = '{500, 600, 700, -800};
        send4(tv, -2, 1'b0, 1'b1, od, 0);
        repeat (2) @(negedge clk);
        check("bp_held_valid", 32'(out_valid4), 32'd1);
        check("bp_busy", 32'(busy4), 32'd1);
        ready_cmd4 = 1'b1;
        wait_idle4();

        // random tiles with random back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) tv[i] = rnd_val();
            shuffle();
            send4(tv, rnd_val(), 1'($urandom_range(0, 1)), 1'b1, od, 2);
            wait_idle4();
        end
        rand_ready = 1'b0;

        // single channel: negative saturation and minimum latency
        send1(32'h8000_0000, -1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid1) break;
        end
        check("latency1", 32'(cyc - last_raise1), 32'd4);
        wait_idle1();
        for (int t = 0; t < 15; t++) begin
            send1(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
            wait_idle1();
        end
        check("overrun1", 32'(overrun1), 32'd0);

        repeat (4) @(negedge clk);
        check("queue4_drained", 32'(exp_q4.size()), 32'd0);
        check("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
